// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode-to-execute pipeline register.
// Captures the decode-stage control bits and operands and presents them to
// execute one cycle later. Supports stall (hold), flush (bubble) and a
// syscall freeze that parks a syscall in execute until the handler is done.
//
// Pipeline control semantics (no valid/ready handshake here):
//   flushE  - load a bubble on the next edge; wins over stallE.
//   stallE  - hold every output on the next edge.
//   neither - load all D inputs, validE=1 one cycle later.
//   While frozen, stallE/flushE are ignored; syscall_done releases the freeze
//   and the same edge applies the flush/stall/load rules above.
// The FSM state is visible on syscall_pendingE (FREEZE decodes to 1).
module id_ex_pipe_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallE,
  input  logic              flushE,
  input  logic              syscall_done,
  input  logic              reg_writeD,
  input  logic              mem_to_regD,
  input  logic              mem_writeD,
  input  logic              alu_srcD,
  input  logic              reg_destD,
  input  logic              syscallD,
  input  logic [3:0]        alu_opD,
  input  logic [2:0]        branch_variantD,
  input  logic [4:0]        shamtD,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [DATA_W-1:0] immD,
  input  logic [DATA_W-1:0] pc_plus4D,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  output logic              reg_writeE,
  output logic              mem_to_regE,
  output logic              mem_writeE,
  output logic              alu_srcE,
  output logic              reg_destE,
  output logic              syscallE,
  output logic [3:0]        alu_opE,
  output logic [2:0]        branch_variantE,
  output logic [4:0]        shamtE,
  output logic [DATA_W-1:0] rd1E,
  output logic [DATA_W-1:0] rd2E,
  output logic [DATA_W-1:0] immE,
  output logic [DATA_W-1:0] pc_plus4E,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic              validE,
  output logic              syscall_pendingE,
  output logic              stall_req
);

  // Branch class meaning "not a branch" (BV_NONE in mips.h).
  localparam logic [2:0] BV_NONE = 3'd0;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   update_en;
  logic   load_en;

  // Decide whether this edge updates the register and where the FSM goes.
  // A freeze is entered only on an edge that actually loads a syscall, so a
  // stalled or flushed syscall never re-triggers it.
  always_comb begin
    update_en  = (state == RUN) || syscall_done;
    load_en    = update_en && !flushE && !stallE;
    state_next = state;
    if (update_en) begin
      state_next = (load_en && syscallD) ? FREEZE : RUN;
    end
  end

  // FSM state register; reset always returns to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Payload register: reset and flush both produce a zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_writeE      <= 1'b0;
      mem_to_regE     <= 1'b0;
      mem_writeE      <= 1'b0;
      alu_srcE        <= 1'b0;
      reg_destE       <= 1'b0;
      syscallE        <= 1'b0;
      alu_opE         <= 4'd0;
      branch_variantE <= BV_NONE;
      shamtE          <= 5'd0;
      rd1E            <= '0;
      rd2E            <= '0;
      immE            <= '0;
      pc_plus4E       <= '0;
      rsE             <= 5'd0;
      rtE             <= 5'd0;
      rdE             <= 5'd0;
      validE          <= 1'b0;
    end else if (update_en && flushE) begin
      reg_writeE      <= 1'b0;
      mem_to_regE     <= 1'b0;
      mem_writeE      <= 1'b0;
      alu_srcE        <= 1'b0;
      reg_destE       <= 1'b0;
      syscallE        <= 1'b0;
      alu_opE         <= 4'd0;
      branch_variantE <= BV_NONE;
      shamtE          <= 5'd0;
      rd1E            <= '0;
      rd2E            <= '0;
      immE            <= '0;
      pc_plus4E       <= '0;
      rsE             <= 5'd0;
      rtE             <= 5'd0;
      rdE             <= 5'd0;
      validE          <= 1'b0;
    end else if (load_en) begin
      reg_writeE      <= reg_writeD;
      mem_to_regE     <= mem_to_regD;
      mem_writeE      <= mem_writeD;
      alu_srcE        <= alu_srcD;
      reg_destE       <= reg_destD;
      syscallE        <= syscallD;
      alu_opE         <= alu_opD;
      branch_variantE <= branch_variantD;
      shamtE          <= shamtD;
      rd1E            <= rd1D;
      rd2E            <= rd2D;
      immE            <= immD;
      pc_plus4E       <= pc_plus4D;
      rsE             <= rsD;
      rtE             <= rtD;
      rdE             <= rdD;
      validE          <= 1'b1;
    end
  end

  assign syscall_pendingE = (state == FREEZE);
  assign stall_req        = syscall_pendingE;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed steps followed by a randomized run, all checked
// against a behavioural model of the execute-stage contents.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int VW     = 6 + 4 + 3 + 5 + 4 * DATA_W + 15;

  // Clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic              stallE, flushE, syscall_done;
  logic              reg_writeD, mem_to_regD, mem_writeD, alu_srcD, reg_destD, syscallD;
  logic [3:0]        alu_opD;
  logic [2:0]        branch_variantD;
  logic [4:0]        shamtD, rsD, rtD, rdD;
  logic [DATA_W-1:0] rd1D, rd2D, immD, pc_plus4D;
  logic              reg_writeE, mem_to_regE, mem_writeE, alu_srcE, reg_destE, syscallE;
  logic [3:0]        alu_opE;
  logic [2:0]        branch_variantE;
  logic [4:0]        shamtE, rsE, rtE, rdE;
  logic [DATA_W-1:0] rd1E, rd2E, immE, pc_plus4E;
  logic              validE, syscall_pendingE, stall_req;

  id_ex_pipe_reg #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE),
    .syscall_done(syscall_done),
    .reg_writeD(reg_writeD), .mem_to_regD(mem_to_regD), .mem_writeD(mem_writeD),
    .alu_srcD(alu_srcD), .reg_destD(reg_destD), .syscallD(syscallD),
    .alu_opD(alu_opD), .branch_variantD(branch_variantD), .shamtD(shamtD),
    .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .pc_plus4D(pc_plus4D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .reg_writeE(reg_writeE), .mem_to_regE(mem_to_regE), .mem_writeE(mem_writeE),
    .alu_srcE(alu_srcE), .reg_destE(reg_destE), .syscallE(syscallE),
    .alu_opE(alu_opE), .branch_variantE(branch_variantE), .shamtE(shamtE),
    .rd1E(rd1E), .rd2E(rd2E), .immE(immE), .pc_plus4E(pc_plus4E),
    .rsE(rsE), .rtE(rtE), .rdE(rdE),
    .validE(validE), .syscall_pendingE(syscall_pendingE), .stall_req(stall_req)
  );

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  // Behavioural model: what execute holds, whether it is real, whether frozen.
  logic [VW-1:0] m_fields = '0;
  logic          m_valid  = 1'b0;
  logic          m_frozen = 1'b0;

  function automatic logic [VW-1:0] d_vec();
    return {reg_writeD, mem_to_regD, mem_writeD, alu_srcD, reg_destD, syscallD,
            alu_opD, branch_variantD, shamtD, rd1D, rd2D, immD, pc_plus4D,
            rsD, rtD, rdD};
  endfunction

  function automatic logic [VW-1:0] e_vec();
    return {reg_writeE, mem_to_regE, mem_writeE, alu_srcE, reg_destE, syscallE,
            alu_opE, branch_variantE, shamtE, rd1E, rd2E, immE, pc_plus4E,
            rsE, rtE, rdE};
  endfunction

  task automatic model_reset();
    m_fields = '0;
    m_valid  = 1'b0;
    m_frozen = 1'b0;
  endtask

  // One rising edge of the model. A frozen slot only moves when the handler
  // says done; a moving slot takes bubble, hold or the new instruction.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_frozen || syscall_done) begin
      if (flushE) begin
        m_fields = '0;
        m_valid  = 1'b0;
        m_frozen = 1'b0;
      end else if (stallE) begin
        m_frozen = 1'b0;
      end else begin
        m_fields = d_vec();
        m_valid  = 1'b1;
        m_frozen = syscallD;
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs,
                           input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_vec({tag, ".fields"}, e_vec(), m_fields);
    check_bit({tag, ".validE"}, validE, m_valid);
    check_bit({tag, ".pending"}, syscall_pendingE, m_frozen);
    check_bit({tag, ".stall_req"}, stall_req, m_frozen);
  endtask

  // Driver tasks
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_d(input logic sys);
    {reg_writeD, mem_to_regD, mem_writeD, alu_srcD, reg_destD} = 5'($urandom);
    syscallD        = sys;
    alu_opD         = 4'($urandom);
    branch_variantD = 3'($urandom);
    shamtD          = 5'($urandom);
    rd1D            = $urandom;
    rd2D            = $urandom;
    immD            = $urandom;
    pc_plus4D       = $urandom;
    rsD             = 5'($urandom);
    rtD             = 5'($urandom);
    rdD             = 5'($urandom);
  endtask

  task automatic clear_ctl();
    stallE       = 1'b0;
    flushE       = 1'b0;
    syscall_done = 1'b0;
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    check_word({tag, ".bv"}, 32'(branch_variantE), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clear_ctl();
    rand_d(1'b0);

    // Reset state while rst_n is held low across edges
    tick("reset_hold");
    tick("reset_hold2");
    #2 rst_n = 1'b1;

    // addiu loaded, then reset mid-cycle
    rand_d(1'b0);
    {reg_writeD, mem_to_regD, mem_writeD, alu_srcD, reg_destD} = 5'b10010;
    immD = 32'h0000_FFFF;
    tick("addiu_load");
    check_word("addiu_imm", immE, 32'h0000_FFFF);
    async_reset("reset_mid");

    // Normal flow: three back-to-back instructions
    rand_d(1'b0); rd1D = 32'h11;
    tick("flow1"); check_word("flow1_rd1", rd1E, 32'h11);
    rand_d(1'b0); rd1D = 32'h22;
    tick("flow2"); check_word("flow2_rd1", rd1E, 32'h22);
    check_bit("flow2_valid", validE, 1'b1);

    // Stall holds 0x22 for two cycles, then 0x33 lands
    rand_d(1'b0); rd1D = 32'h33; stallE = 1'b1;
    tick("stall1"); check_word("stall1_rd1", rd1E, 32'h22);
    tick("stall2"); check_word("stall2_rd1", rd1E, 32'h22);
    stallE = 1'b0;
    tick("flow3"); check_word("flow3_rd1", rd1E, 32'h33);

    // Stall and flush together give a bubble
    rand_d(1'b0); reg_writeD = 1'b1; mem_writeD = 1'b1;
    stallE = 1'b1; flushE = 1'b1;
    tick("stall_flush");
    check_bit("stall_flush_valid", validE, 1'b0);
    check_bit("stall_flush_rw", reg_writeE, 1'b0);
    check_bit("stall_flush_mw", mem_writeE, 1'b0);
    clear_ctl();

    // Syscall freeze: held through flush toggling and D changes
    rand_d(1'b1);
    tick("sys_enter");
    check_bit("sys_enter_pend", syscall_pendingE, 1'b1);
    check_bit("sys_enter_req", stall_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rand_d(1'($urandom));
      flushE = ~flushE;
      stallE = 1'($urandom);
      tick("sys_frozen");
    end
    clear_ctl();
    rand_d(1'b0); rd1D = 32'h44; syscall_done = 1'b1;
    tick("sys_release");
    check_word("sys_release_rd1", rd1E, 32'h44);
    check_bit("sys_release_pend", syscall_pendingE, 1'b0);
    clear_ctl();

    // Syscall arriving with flush is discarded
    rand_d(1'b1); flushE = 1'b1;
    tick("sys_flushed");
    check_bit("sys_flushed_pend", syscall_pendingE, 1'b0);
    check_bit("sys_flushed_req", stall_req, 1'b0);
    clear_ctl();

    // Spurious done in RUN under stall changes nothing
    rand_d(1'b0); rd1D = 32'h55;
    tick("pre_spur");
    rand_d(1'b0); syscall_done = 1'b1; stallE = 1'b1;
    tick("spurious_done");
    check_word("spurious_rd1", rd1E, 32'h55);
    clear_ctl();

    // Enter freeze, then reset mid-cycle
    rand_d(1'b1);
    tick("sys_enter2");
    async_reset("reset_in_freeze");
    check_bit("reset_in_freeze_pend", syscall_pendingE, 1'b0);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      rand_d($urandom_range(0, 5) == 0);
      stallE       = ($urandom_range(0, 3) == 0);
      flushE       = ($urandom_range(0, 5) == 0);
      syscall_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rand_reset");
      end
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register. Captures every control output of the decode-stage control unit, plus the decoded operands, and presents them to the execute stage one cycle later.
- Supports stall (hold), flush (bubble insertion) and a syscall freeze. The freeze holds a syscall in execute until the syscall handler signals completion.
- Sits between the control unit/register file and the ALU/forwarding logic.

Parameters:
- DATA_W, 32, width of register operands, immediate and PC values.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stallE  input  1  hazard unit: hold current contents.
- flushE  input  1  hazard unit: load a bubble.
- syscall_done  input  1  single-cycle pulse from syscall handler: release the freeze.
- reg_writeD, mem_to_regD, mem_writeD, alu_srcD, reg_destD, syscallD  input  1 each  control bits from decode.
- alu_opD  input  4  ALU operation.
- branch_variantD  input  3  branch class, BV_* encoding from mips.h.
- shamtD  input  5  shift amount (already forced to 16 for LUI).
- rd1D, rd2D  input  DATA_W each  register-file read data.
- immD  input  DATA_W  extended immediate.
- pc_plus4D  input  DATA_W  PC+4 of the decode instruction.
- rsD, rtD, rdD  input  5 each  register IDs.
- <each of the above>E  output  same width  registered copy, execute stage.
- validE  output  1  execute slot holds a real instruction, not a bubble.
- syscall_pendingE  output  1  freeze active.
- stall_req  output  1  to hazard unit: stall fetch/decode; equals syscall_pendingE.

Behaviour:
- Reset (rst_n low, asynchronous): all E outputs = 0, branch_variantE = BV_NONE, validE = 0, syscall_pendingE = 0.
  - Reset wins over every other input.
  - Release is synchronous to the next clk edge.
- State machine, two states:
  - RUN: normal pipeline operation.
  - FREEZE: a valid syscall is held in execute.
- RUN, next-edge priority:
  1. flushE=1: load bubble. All control bits 0, alu_opE=0, branch_variantE=BV_NONE, validE=0. Data fields are don't-care but are zeroed. flushE wins over stallE.
  2. stallE=1: hold all outputs unchanged.
  3. Otherwise: load all D inputs and set validE=1. Latency is exactly 1 cycle.
- RUN to FREEZE: on the edge that loads syscallD=1 with validE becoming 1. syscall_pendingE=1 from that cycle onward.
- FREEZE:
  - All outputs held; stallE and flushE are ignored.
  - stall_req=1, combinational from state.
- FREEZE to RUN: on the edge where syscall_done=1.
  - That same edge performs the RUN update (flush/stall/load rules above), using the current inputs.
  - syscall_pendingE returns to 0.
- syscall_done while in RUN: ignored.
- A syscall that arrives while flushE=1 is discarded: it becomes a bubble and no freeze occurs.
- A syscall held by stallE in RUN does not re-trigger FREEZE. FREEZE is entered only on a load edge.
- Reset while in FREEZE: returns to RUN with a bubble.
- No arithmetic inside the block. Widths pass through unchanged; no sign extension is done here.

Test Plan:
- Reset mid-stream: load addiu (reg_writeD=1, alu_srcD=1, immD=0x0000FFFF), assert rst_n=0 between edges -> all outputs 0 immediately, validE=0, branch_variantE=BV_NONE.
- Normal flow: three back-to-back instructions, rd1D=0x11/0x22/0x33 -> rd1E shows each value exactly one cycle later, validE=1 throughout.
- Stall vs flush: rd1E=0x22 held while stallE=1 for 2 cycles; then stallE=1 and flushE=1 together -> next edge gives a bubble (validE=0, reg_writeE=0, mem_writeE=0).
- Syscall freeze: load syscallD=1 -> syscall_pendingE=1 and stall_req=1. For 4 cycles, change every D input and toggle flushE -> E outputs unchanged. Pulse syscall_done with rd1D=0x44 -> next edge rd1E=0x44 and syscall_pendingE=0.
- Flushed syscall: syscallD=1 with flushE=1 -> validE=0, syscall_pendingE stays 0, stall_req stays 0.
- Spurious done plus reset in freeze: syscall_done in RUN -> no change. Enter FREEZE, then pulse rst_n low -> syscall_pendingE=0, validE=0.
